// File: rtl/row_feeder.sv
// Streams feature-map rows from a FWFT FIFO into a three-slot row register file.
// Writes land one cycle after each pop; an empty FIFO stalls the current group.
module row_feeder (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [7:0]  row_total,
   input  logic        fifo_empty,
   input  logic [63:0] fifo_rdata,
   output logic        fifo_rd,
   output logic [2:0]  wr_en,
   output logic [1:0]  wr_addr,
   output logic [63:0] wr_data,
   output logic        full_row,
   output logic        three_row_ready,
   output logic [1:0]  top_slot,
   output logic        busy,
   output logic        done
);

   typedef enum logic [2:0] {
      IDLE,
      PRELOAD,
      FIRE,
      WAIT,
      REFILL
   } state_t;

   localparam logic [3:0] PRELOAD_WORDS = 4'd12;
   localparam logic [3:0] REFILL_WORDS  = 4'd4;

   state_t      state_q, state_d;
   logic [7:0]  row_total_q, row_total_d;
   logic [7:0]  rows_loaded_q, rows_loaded_d;
   logic [3:0]  word_cnt_q, word_cnt_d;
   logic [1:0]  wait_cnt_q, wait_cnt_d;
   logic [2:0]  wr_en_q, wr_en_d;
   logic [1:0]  wr_addr_q, wr_addr_d;
   logic [63:0] wr_data_q, wr_data_d;
   logic        full_row_q, full_row_d;
   logic        trr_q, trr_d;
   logic [1:0]  top_slot_q, top_slot_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [1:0]  wr_slot;
   logic        pass_end;

   always_comb begin
      state_d       = state_q;
      row_total_d   = row_total_q;
      rows_loaded_d = rows_loaded_q;
      word_cnt_d    = word_cnt_q;
      wait_cnt_d    = wait_cnt_q;
      top_slot_d    = top_slot_q;
      wr_en_d       = 3'b000;
      wr_addr_d     = wr_addr_q;
      wr_data_d     = wr_data_q;
      done_d        = 1'b0;
      fifo_rd       = 1'b0;
      wr_slot       = 2'd0;
      pass_end      = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               if (row_total >= 8'd3) begin
                  state_d       = PRELOAD;
                  row_total_d   = row_total;
                  rows_loaded_d = 8'd0;
                  word_cnt_d    = 4'd0;
                  wait_cnt_d    = 2'd0;
                  top_slot_d    = 2'd0;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         PRELOAD: begin
            fifo_rd = !fifo_empty && (word_cnt_q < PRELOAD_WORDS);
            wr_slot = word_cnt_q[3:2];
            // Counter hits 12 on the cycle the last word is being written.
            if (word_cnt_q == PRELOAD_WORDS) begin
               state_d       = FIRE;
               rows_loaded_d = 8'd3;
            end
         end
         FIRE: begin
            state_d    = WAIT;
            wait_cnt_d = 2'd0;
            word_cnt_d = 4'd0;
         end
         WAIT: begin
            wait_cnt_d = wait_cnt_q + 2'd1;
            if (wait_cnt_q == 2'd3) begin
               if (rows_loaded_q == row_total_q) begin
                  state_d  = IDLE;
                  done_d   = 1'b1;
                  pass_end = 1'b1;
               end else begin
                  state_d = REFILL;
               end
            end
         end
         REFILL: begin
            fifo_rd = !fifo_empty && (word_cnt_q < REFILL_WORDS);
            wr_slot = top_slot_q;
            if (word_cnt_q == REFILL_WORDS) begin
               state_d       = FIRE;
               rows_loaded_d = rows_loaded_q + 8'd1;
               top_slot_d    = (top_slot_q == 2'd2) ? 2'd0 : top_slot_q + 2'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (fifo_rd) begin
         word_cnt_d = word_cnt_q + 4'd1;
         wr_en_d    = 3'b001 << wr_slot;
         wr_addr_d  = word_cnt_q[1:0];
         wr_data_d  = fifo_rdata;
      end

      full_row_d = (state_d == FIRE);
      busy_d     = (state_d != IDLE) || pass_end;
      // Window stays valid through the done cycle and drops right after it.
      trr_d      = full_row_d ? 1'b1 : (done_q ? 1'b0 : trr_q);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         row_total_q   <= 8'd0;
         rows_loaded_q <= 8'd0;
         word_cnt_q    <= 4'd0;
         wait_cnt_q    <= 2'd0;
         wr_en_q       <= 3'b000;
         wr_addr_q     <= 2'd0;
         wr_data_q     <= 64'd0;
         full_row_q    <= 1'b0;
         trr_q         <= 1'b0;
         top_slot_q    <= 2'd0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         row_total_q   <= row_total_d;
         rows_loaded_q <= rows_loaded_d;
         word_cnt_q    <= word_cnt_d;
         wait_cnt_q    <= wait_cnt_d;
         wr_en_q       <= wr_en_d;
         wr_addr_q     <= wr_addr_d;
         wr_data_q     <= wr_data_d;
         full_row_q    <= full_row_d;
         trr_q         <= trr_d;
         top_slot_q    <= top_slot_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign wr_en           = wr_en_q;
   assign wr_addr         = wr_addr_q;
   assign wr_data         = wr_data_q;
   assign full_row        = full_row_q;
   assign three_row_ready = trr_q;
   assign top_slot        = top_slot_q;
   assign busy            = busy_q;
   assign done            = done_q;

endmodule
